// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared types and constants for the fetch stage.
//            Optional feature macro: FETCH_MISALIGN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
    localparam u32 NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   instr;
`ifdef FETCH_MISALIGN_EN
        logic misalign;
`endif
    } fetch_data_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction bus and decode handshake bundle of the fetch stage.
//            Optional feature macro: FETCH_MISALIGN_EN (adds f_misalign).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_data_ok;
    u32   iresp_data;
    logic f_valid;
    u64   f_pc;
    u32   f_instr;
    logic f_ready;
`ifdef FETCH_MISALIGN_EN
    logic f_misalign;
`endif

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data,
        output f_valid,
        output f_pc,
        output f_instr,
`ifdef FETCH_MISALIGN_EN
        output f_misalign,
`endif
        input  f_ready
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data,
        input  f_valid,
        input  f_pc,
        input  f_instr,
`ifdef FETCH_MISALIGN_EN
        input  f_misalign,
`endif
        output f_ready
    );

endinterface

`default_nettype wire

// File: rtl/fetch_holdbuf.sv
// ============================================================================
// Module   : fetch_holdbuf
// Brief    : One-entry skid register holding a response decode could not take.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_holdbuf
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  fetch_data_t din,
    output fetch_data_t dout
);

    fetch_data_t entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else if (flush || drain) begin
            entry.valid <= 1'b0;
        end else if (load) begin
            entry <= din;
        end
    end

    assign dout = entry;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Fetch stage owning the PC; issues bus reads, feeds decode.
//            Optional feature macro: FETCH_MISALIGN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT
)(
    input  logic         clk,
    input  logic         reset,
    input  u64           pc_next,
    input  logic         redirect,
    output u64           pc_cur,
    fetch_unit_if.master bus
);

    fetch_state_t state, state_nx;
    u64           pc_q, pc_nx, addr_q;
    fetch_data_t  fout_q, fout_nx;
    fetch_data_t  hb_in, hb_data;
    logic         hb_load, hb_drain, hb_flush;
    logic         slot_free;
    logic         misaligned;

`ifdef FETCH_MISALIGN_EN
    logic trap_q, trap_nx;
    assign misaligned = (pc_q[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) trap_q <= 1'b0;
        else        trap_q <= trap_nx;
    end
`else
    assign misaligned = 1'b0;
`endif

    assign slot_free = !fout_q.valid || bus.f_ready;

    // Gated with reset so an abandoned request is withdrawn the instant reset hits.
    assign bus.ireq_valid = reset && (((state == REQ) && !misaligned) || (state == DRAIN));
    assign bus.ireq_addr  = (state == REQ) ? pc_q : addr_q;

    assign pc_cur      = pc_q;
    assign bus.f_valid = fout_q.valid;
    assign bus.f_pc    = fout_q.pc;
    assign bus.f_instr = fout_q.instr;
`ifdef FETCH_MISALIGN_EN
    assign bus.f_misalign = fout_q.misalign;
`endif

    fetch_holdbuf u_holdbuf (
        .clk   (clk),
        .reset (reset),
        .load  (hb_load),
        .drain (hb_drain),
        .flush (hb_flush),
        .din   (hb_in),
        .dout  (hb_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= REQ;
            pc_q   <= PC_RESET;
            addr_q <= PC_RESET;
            fout_q <= '0;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            fout_q <= fout_nx;
            if (state == REQ) addr_q <= pc_q;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        fout_nx  = fout_q;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        hb_flush = 1'b0;
`ifdef FETCH_MISALIGN_EN
        trap_nx  = trap_q;
`endif
        hb_in       = '0;
        hb_in.valid = 1'b1;
        hb_in.pc    = pc_q;
        hb_in.instr = bus.iresp_data;

        if (fout_q.valid && bus.f_ready) fout_nx.valid = 1'b0;

        case (state)
            REQ: begin
                if (redirect) begin
                    pc_nx         = pc_next;
                    fout_nx.valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
                    trap_nx       = 1'b0;
`endif
                    if (!bus.iresp_data_ok && !misaligned) state_nx = DRAIN;
                end else if (misaligned) begin
`ifdef FETCH_MISALIGN_EN
                    if (!trap_q && slot_free) begin
                        fout_nx          = '0;
                        fout_nx.valid    = 1'b1;
                        fout_nx.pc       = pc_q;
                        fout_nx.instr    = NOP_INSTR;
                        fout_nx.misalign = 1'b1;
                        trap_nx          = 1'b1;
                    end
`endif
                end else if (bus.iresp_data_ok) begin
                    pc_nx = pc_next;
                    if (slot_free) begin
                        fout_nx = hb_in;
                    end else begin
                        hb_load  = 1'b1;
                        state_nx = STALL;
                    end
                end
            end
            STALL: begin
                if (redirect) begin
                    hb_flush      = 1'b1;
                    fout_nx.valid = 1'b0;
                    pc_nx         = pc_next;
                    state_nx      = REQ;
                end else if (bus.f_ready) begin
                    fout_nx  = hb_data;
                    hb_drain = 1'b1;
                    state_nx = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_nx         = pc_next;
                    fout_nx.valid = 1'b0;
                end
                // A response landing with a redirect still retires the stale request.
                if (bus.iresp_data_ok) state_nx = REQ;
            end
            default: state_nx = REQ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a transaction model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_next = '0;
    logic        redirect = 1'b0;
    logic [63:0] pc_cur;

    fetch_unit_if bus ();

    fetch_unit #(.PC_RESET(RST_PC)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_next  (pc_next),
        .redirect (redirect),
        .pc_cur   (pc_cur),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: the PC, the word on the decode port, anything parked behind it,
    // and whether a discarded request is still owed a response.
    logic [63:0] m_pc = RST_PC;
    bit          m_fv = 1'b0;
    logic [63:0] m_fpc = '0;
    logic [31:0] m_finstr = '0;
    ent_t        skid[$];
    bit          m_drain = 1'b0;
    logic [63:0] m_drain_addr = '0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_req();
        return skid.size() == 0;
    endfunction

    function automatic logic [63:0] exp_addr();
        return m_drain ? m_drain_addr : m_pc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit dok, input bit rdy, input bit redir,
                              input logic [63:0] nxt, input logic [31:0] data);
        bit req_on;
        ent_t e;
        req_on = exp_req();
        if (redir) begin
            if (req_on && !dok) begin
                if (!m_drain) m_drain_addr = m_pc;
                m_drain = 1'b1;
            end else begin
                m_drain = 1'b0;
            end
            skid.delete();
            m_fv = 1'b0;
            m_pc = nxt;
        end else if (skid.size() != 0) begin
            if (rdy) begin
                e = skid.pop_front();
                m_fv = 1'b1;
                m_fpc = e.pc;
                m_finstr = e.instr;
            end
        end else if (m_drain) begin
            if (dok) m_drain = 1'b0;
        end else begin
            if (m_fv && rdy) m_fv = 1'b0;
            if (dok) begin
                if (!m_fv) begin
                    m_fv = 1'b1;
                    m_fpc = m_pc;
                    m_finstr = data;
                end else begin
                    e.pc = m_pc;
                    e.instr = data;
                    skid.push_back(e);
                end
                m_pc = nxt;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input bit dok, input bit rdy, input bit redir, input logic [63:0] tgt);
        logic [63:0] a;
        logic [31:0] d;
        logic [63:0] nxt;
        bit okv;
        a   = exp_addr();
        d   = instr_of(a);
        okv = dok && exp_req();
        nxt = redir ? tgt : m_pc + 64'd4;
        bus.iresp_data_ok = okv;
        bus.iresp_data    = okv ? d : 32'hDEAD_BEEF;
        bus.f_ready       = rdy;
        redirect          = redir;
        pc_next           = nxt;
        model_step(okv, rdy, redir, nxt, d);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            #2;
            chk("pc_cur", pc_cur, m_pc);
            chk("ireq_valid", {63'd0, bus.ireq_valid}, {63'd0, exp_req()});
            if (exp_req()) chk("ireq_addr", bus.ireq_addr, exp_addr());
            chk("f_valid", {63'd0, bus.f_valid}, {63'd0, m_fv});
            if (m_fv) begin
                chk("f_pc", bus.f_pc, m_fpc);
                chk("f_instr", {32'd0, bus.f_instr}, {32'd0, m_finstr});
            end
        end
    end

    initial begin
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = '0;
        bus.f_ready       = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        chk("rst_pc_cur", pc_cur, RST_PC);
        chk("rst_ireq_addr", bus.ireq_addr, RST_PC);
        chk("rst_f_valid", {63'd0, bus.f_valid}, 64'd0);
        chk("rst_f_pc", bus.f_pc, 64'd0);
        chk("rst_f_instr", {32'd0, bus.f_instr}, 64'd0);

        reset  = 1'b1;
        chk_en = 1'b1;

        // Zero-wait bus, decode always ready.
        drive_cycle(1, 1, 0, '0);
        chk("zw_f_pc0", bus.f_pc, 64'h8000_0000);
        chk("zw_f_instr0", {32'd0, bus.f_instr}, 64'h9357_9BDF);
        drive_cycle(1, 1, 0, '0);
        chk("zw_f_pc1", bus.f_pc, 64'h8000_0004);
        drive_cycle(1, 1, 0, '0);
        chk("zw_f_pc2", bus.f_pc, 64'h8000_0008);
        chk("zw_ireq_valid", {63'd0, bus.ireq_valid}, 64'd1);

        // Three-cycle bus latency: address stays put.
        drive_cycle(0, 1, 0, '0);
        chk("lat_addr0", bus.ireq_addr, 64'h8000_000C);
        chk("lat_fv0", {63'd0, bus.f_valid}, 64'd0);
        drive_cycle(0, 1, 0, '0);
        chk("lat_addr1", bus.ireq_addr, 64'h8000_000C);
        drive_cycle(1, 1, 0, '0);
        chk("lat_f_pc", bus.f_pc, 64'h8000_000C);
        chk("lat_fv", {63'd0, bus.f_valid}, 64'd1);

        // Back-pressure pushes the response into the skid entry.
        drive_cycle(1, 0, 0, '0);
        chk("stall_ireq", {63'd0, bus.ireq_valid}, 64'd0);
        chk("stall_f_pc", bus.f_pc, 64'h8000_000C);
        drive_cycle(0, 1, 0, '0);
        chk("skid_f_pc", bus.f_pc, 64'h8000_0010);
        chk("skid_next_addr", bus.ireq_addr, 64'h8000_0014);

        // Redirect with a request outstanding: drain, then new target.
        drive_cycle(0, 1, 1, 64'h8000_1000);
        chk("drain_addr", bus.ireq_addr, 64'h8000_0014);
        chk("drain_fv", {63'd0, bus.f_valid}, 64'd0);
        chk("drain_pc_cur", pc_cur, 64'h8000_1000);
        drive_cycle(1, 1, 0, '0);
        chk("drain_fv_after", {63'd0, bus.f_valid}, 64'd0);
        chk("drain_new_addr", bus.ireq_addr, 64'h8000_1000);
        drive_cycle(1, 1, 0, '0);
        chk("tgt_f_pc", bus.f_pc, 64'h8000_1000);

        // Redirect coinciding with a response and a handshake.
        drive_cycle(1, 1, 1, 64'h8000_2000);
        chk("kill_fv", {63'd0, bus.f_valid}, 64'd0);
        chk("kill_addr", bus.ireq_addr, 64'h8000_2000);
        drive_cycle(1, 1, 0, '0);
        chk("kill_f_pc", bus.f_pc, 64'h8000_2000);

        // PC wraps modulo 2^64.
        drive_cycle(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        drive_cycle(1, 1, 0, '0);
        drive_cycle(1, 1, 0, '0);
        chk("wrap_f_pc", bus.f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc_cur", pc_cur, 64'h0);

        for (int i = 0; i < 4000; i++) begin
            bit dok, rdy, redir;
            logic [63:0] tgt;
            dok   = ($urandom_range(0, 3) != 0) || (i < 200);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 11) == 0);
            tgt   = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
            drive_cycle(dok, rdy, redir, tgt);
        end

        // Asynchronous reset withdraws the request immediately.
        chk_en = 1'b0;
        bus.iresp_data_ok = 1'b0;
        redirect = 1'b0;
        drive_cycle(0, 1, 0, '0);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        chk("areset_pc_cur", pc_cur, RST_PC);
        chk("areset_f_valid", {63'd0, bus.f_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
